// File: rtl/vedic_8x8_sequencer.sv
// Unsigned 8x8 -> 16-bit multiply built by sequencing one shared 4x4 core
// over four nibble partial products and shift-accumulating the results.
module vedic_8x8_sequencer #(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  input  logic        abort,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_product,
  output logic        busy,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_p
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAST_CNT = 3'(MUL_LATENCY);

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [1:0]  r_k;
  logic [2:0]  r_cnt;
  logic [15:0] r_acc;
  logic [15:0] r_product;

  logic        w_accept;
  logic        w_beat_end;
  logic        w_last_partial;
  logic [15:0] w_partial;
  logic [15:0] w_sum;

  assign w_accept       = (r_state == S_IDLE) && in_valid;
  assign w_beat_end     = (r_state == S_MUL) && (r_cnt == LAST_CNT);
  assign w_last_partial = (r_k == 2'd3);
  assign w_sum          = r_acc + w_partial;

  // Partial k weight: k0 at bit 0, k1/k2 at bit 4, k3 at bit 8.
  always_comb begin
    w_partial = '0;
    unique case (r_k)
      2'd0:    w_partial = {8'h00, mul_p};
      2'd1,
      2'd2:    w_partial = {4'h0, mul_p, 4'h0};
      default: w_partial = {mul_p, 8'h00};
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) w_next_state = S_MUL;
      end
      S_MUL: begin
        if (abort) begin
          w_next_state = S_IDLE;
        end else if (w_beat_end && w_last_partial) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (abort || out_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    mul_a     = 4'h0;
    mul_b     = 4'h0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_MUL: begin
        mul_a = r_k[1] ? r_a[7:4] : r_a[3:0];
        mul_b = r_k[0] ? r_b[7:4] : r_b[3:0];
      end
      S_DONE: begin
        out_valid = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_k       <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_a   <= in_a;
      r_b   <= in_b;
      r_k   <= '0;
      r_cnt <= '0;
      r_acc <= '0;
    end else if (r_state == S_MUL) begin
      if (abort) begin
        r_k   <= '0;
        r_cnt <= '0;
        r_acc <= '0;
      end else if (w_beat_end) begin
        r_acc <= w_sum;
        r_k   <= r_k + 2'd1;
        r_cnt <= '0;
        if (w_last_partial) r_product <= w_sum;
      end else begin
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

  assign out_product = r_product;

endmodule

// File: tb/tb_vedic_8x8_sequencer.sv
// Self-checking bench: a registered 4x4 core (latency 1) and a combinational
// core (latency 0), each driving its own sequencer, checked against a*b.
module tb_vedic_8x8_sequencer;

  localparam int TB_L = 1;
  localparam int SLOTS = 4 * (TB_L + 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        abort = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_product;
  logic        busy;
  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic [7:0]  mul_p;
  logic [7:0]  core_q;

  logic        in_valid0 = 1'b0;
  logic        in_ready0;
  logic [7:0]  in_a0 = '0;
  logic [7:0]  in_b0 = '0;
  logic        abort0 = 1'b0;
  logic        out_valid0;
  logic        out_ready0 = 1'b0;
  logic [15:0] out_product0;
  logic        busy0;
  logic [3:0]  mul_a0;
  logic [3:0]  mul_b0;
  logic [7:0]  mul_p0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Registered 4x4 core: product appears one edge after the operands.
  always @(posedge clk) core_q <= mul_a * mul_b;
  assign mul_p  = core_q;
  assign mul_p0 = mul_a0 * mul_b0;

  vedic_8x8_sequencer #(.MUL_LATENCY(TB_L)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
  );

  vedic_8x8_sequencer #(.MUL_LATENCY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_a(in_a0), .in_b(in_b0),
    .abort(abort0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_product(out_product0), .busy(busy0),
    .mul_a(mul_a0), .mul_b(mul_b0), .mul_p(mul_p0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Nibble pair {A,B} presented to the core during partial p.
  function automatic logic [7:0] model_pair(input logic [7:0] a, input logic [7:0] b, input int p);
    case (p)
      0:       return {a[3:0], b[3:0]};
      1:       return {a[3:0], b[7:4]};
      2:       return {a[7:4], b[3:0]};
      default: return {a[7:4], b[7:4]};
    endcase
  endfunction

  task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic abort_at_accept);
    @(negedge clk);
    check("ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    abort = abort_at_accept;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    abort = 1'b0;
    in_a = 8'($urandom);
    in_b = 8'($urandom);
    check("busy_after_accept", busy, 1);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold,
                        input logic abort_at_accept, input logic abort_in_done);
    logic [7:0]  pair;
    logic [15:0] exp_p;
    int j;
    exp_p = 16'(a * b);
    accept(a, b, abort_at_accept);
    j = 0;
    while (!out_valid && j < 64) begin
      if (j < SLOTS) begin
        pair = model_pair(a, b, j / (TB_L + 1));
        check("mul_a_seq", mul_a, pair[7:4]);
        check("mul_b_seq", mul_b, pair[3:0]);
      end
      @(posedge clk);
      #1;
      j++;
    end
    check("latency", j, SLOTS);
    check("out_valid_rise", out_valid, 1);
    check("product", out_product, exp_p);
    check("mul_idle_in_done", {mul_a, mul_b}, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("held_valid", out_valid, 1);
      check("held_product", out_product, exp_p);
      check("no_ready_in_done", in_ready, 0);
      in_valid = 1'($urandom_range(0, 1));
      in_a = 8'($urandom);
      in_b = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    abort = abort_in_done;
    out_ready = abort_in_done ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    abort = 1'b0;
    check("valid_drop", out_valid, 0);
    check("ready_after_handshake", in_ready, 1);
    check("product_retained", out_product, exp_p);
  endtask

  task automatic run_op0(input logic [7:0] a, input logic [7:0] b);
    int j;
    @(negedge clk);
    in_valid0 = 1'b1;
    in_a0 = a;
    in_b0 = b;
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    j = 0;
    while (!out_valid0 && j < 64) begin
      @(posedge clk);
      #1;
      j++;
    end
    check("l0_latency", j, 4);
    check("l0_product", out_product0, 16'(a * b));
    @(negedge clk);
    out_ready0 = 1'b1;
    @(posedge clk);
    #1;
    out_ready0 = 1'b0;
    check("l0_valid_drop", out_valid0, 0);
  endtask

  initial begin
    int stray;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_product", out_product, 0);
    check("rst_busy", busy, 0);
    check("rst_mul", {mul_a, mul_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    run_op(8'd3, 8'd2, 0, 1'b0, 1'b0);
    run_op(8'd200, 8'd150, 1, 1'b0, 1'b0);
    run_op(8'd255, 8'd255, 0, 1'b0, 1'b0);
    run_op(8'd9, 8'd0, 0, 1'b0, 1'b0);
    run_op(8'hF0, 8'h0F, 0, 1'b0, 1'b0);
    run_op(8'd77, 8'd91, 5, 1'b0, 1'b0);
    run_op(8'd12, 8'd34, 0, 1'b1, 1'b0);
    run_op(8'd250, 8'd3, 2, 1'b0, 1'b1);

    // Abort during the third partial.
    accept(8'd123, 8'd45, 1'b0);
    repeat (2 * (TB_L + 1)) @(posedge clk);
    #1;
    check("in_k2_mul_a", mul_a, 4'(8'd123 >> 4));
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_ready", in_ready, 1);
    check("abort_mul", {mul_a, mul_b}, 0);
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stray++;
    end
    check("abort_no_result", stray, 0);
    run_op(8'd17, 8'd13, 0, 1'b0, 1'b0);

    // Reset pulled mid-operation.
    accept(8'd201, 8'd99, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_product", out_product, 0);
    check("midrst_mul", {mul_a, mul_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_ready", in_ready, 1);
    run_op(8'd100, 8'd100, 0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    run_op0(8'd255, 8'd2);
    for (int i = 0; i < 5; i++) run_op0(8'($urandom), 8'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
